// File: rtl/count_sequencer.sv
// count_sequencer: start/pause/direction controller for a downstream 4-bit counter.
// Raw buttons and the counter's finish flag are synchronised, the buttons are
// debounced, and rising edges become single-cycle pulses that drive a four-state FSM.
// Build option: define AUTO_REVERSE_EN to make a finish in RUN reverse the count
// direction and keep running instead of stopping in DONE.
module count_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000  // legal range 2 .. 2^20-1
) (
    input  logic clk_100MHz,
    input  logic reset,       // asynchronous, active-low
    input  logic btn_start,
    input  logic btn_dir,
    input  logic finish,
    output logic enable,
    output logic forward,
    output logic busy
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Bit 0 = start button, bit 1 = direction button, bit 2 = finish flag.
    logic [2:0] raw_in;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [1:0] btn_pulse;
    logic       fin_dly_q;
    logic       start_p;
    logic       dir_p;
    logic       fin_p;

    state_t state_q, state_d;
    logic   forward_q, forward_d;
    logic   enable_q, enable_d;
    logic   busy_q, busy_d;

    assign raw_in = {finish, btn_dir, btn_start};

    // Two-flop synchronisers for all three asynchronous inputs.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // One debouncer per button. The counter advances only while the synchronised
    // sample disagrees with the accepted level; any sample that agrees again
    // (a bounce back) restarts the count, so only a level that stays put for
    // DEBOUNCE_CYCLES consecutive samples is accepted.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d;
            logic             level_dly_q;

            // Next-state for the stability counter and the accepted level.
            always_comb begin
                cnt_d   = cnt_q;
                level_d = level_q;
                if (sync2_q[gi] == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    level_d = sync2_q[gi];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Debounce state plus a delayed copy of the level for edge detection.
            always_ff @(posedge clk_100MHz or negedge reset) begin
                if (!reset) begin
                    cnt_q       <= '0;
                    level_q     <= 1'b0;
                    level_dly_q <= 1'b0;
                end else begin
                    cnt_q       <= cnt_d;
                    level_q     <= level_d;
                    level_dly_q <= level_q;
                end
            end

            // Only a press (0->1 of the accepted level) produces a pulse.
            assign btn_pulse[gi] = level_q & ~level_dly_q;
        end
    endgenerate

    assign start_p = btn_pulse[0];
    assign dir_p   = btn_pulse[1];

    // Edge register for the synchronised finish flag.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            fin_dly_q <= 1'b0;
        end else begin
            fin_dly_q <= sync2_q[2];
        end
    end

    assign fin_p = sync2_q[2] & ~fin_dly_q;

    // FSM next state, direction and the registered output values.
    always_comb begin
        state_d   = state_q;
        forward_d = forward_q;
        unique case (state_q)
            IDLE: begin
                if (dir_p) forward_d = ~forward_q;
                if (start_p) state_d = RUN;
            end
            RUN: begin
                // finish beats a coincident start; direction presses are dropped here.
                if (fin_p) begin
`ifdef AUTO_REVERSE_EN
                    forward_d = ~forward_q;
                    state_d   = RUN;
`else
                    state_d   = DONE;
`endif
                end else if (start_p) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (dir_p) forward_d = ~forward_q;
                if (start_p) state_d = RUN;
            end
            DONE: begin
                if (start_p) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        enable_d = (state_d == RUN);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers; reset forces enable low immediately.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            forward_q <= 1'b1;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            forward_q <= forward_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
        end
    end

    assign enable  = enable_q;
    assign forward = forward_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with a short debounce window.
// Reference model tracks the controller mode and direction from button/finish events.
module tb_count_sequencer;

    localparam int DEB     = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic btn_start = 1'b0;
    logic btn_dir   = 1'b0;
    logic finish    = 1'b0;
    logic enable;
    logic forward;
    logic busy;

    int checks   = 0;
    int failures = 0;

    int m_state  = M_IDLE;
    bit m_fwd    = 1'b1;

    count_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk_100MHz (clk),
        .reset      (rst_n),
        .btn_start  (btn_start),
        .btn_dir    (btn_dir),
        .finish     (finish),
        .enable     (enable),
        .forward    (forward),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_state = M_IDLE;
        m_fwd   = 1'b1;
    endfunction

    function automatic void model_buttons(input bit s, input bit d);
        if (d && (m_state == M_IDLE || m_state == M_PAUSE)) m_fwd = !m_fwd;
        if (s) begin
            case (m_state)
                M_IDLE:  m_state = M_RUN;
                M_RUN:   m_state = M_PAUSE;
                M_PAUSE: m_state = M_RUN;
                default: m_state = M_IDLE;
            endcase
        end
    endfunction

    function automatic void model_finish();
        if (m_state == M_RUN) begin
`ifdef AUTO_REVERSE_EN
            m_fwd = !m_fwd;
`else
            m_state = M_DONE;
`endif
        end
    endfunction

    function automatic bit exp_en();
        return m_state == M_RUN;
    endfunction

    function automatic bit exp_busy();
        return m_state != M_IDLE;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int which, input bit val);
        if (which == 0 || which == 2) btn_start = val;
        if (which == 1 || which == 2) btn_dir   = val;
    endtask

    // Press and release a button (0 start, 1 dir, 2 both), optionally with bounce.
    task automatic press(input int which, input bit bounce);
        if (bounce) begin
            for (int i = 0; i < 4; i++) begin
                set_btn(which, (i % 2) == 0);
                step(1);
            end
        end
        set_btn(which, 1'b1);
        step(DEB + 6);
        if (bounce) begin
            for (int i = 0; i < 3; i++) begin
                set_btn(which, (i % 2) == 1);
                step(1);
            end
        end
        set_btn(which, 1'b0);
        step(DEB + 6);
    endtask

    task automatic pulse_fin();
        finish = 1'b1;
        step(6);
        finish = 1'b0;
        step(4);
    endtask

    // Reset asserted between clock edges, then released.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        model_reset();
        step(2);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(3);
        checks++;
        if ({enable, forward, busy} !== 3'b010) begin
            failures++;
            $display("FAIL reset_hold: got en=%0b fwd=%0b busy=%0b, want en=0 fwd=1 busy=0", enable, forward, busy);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            step(1);
            checks++;
            if ({enable, forward, busy} !== 3'b010) begin
                failures++;
                $display("FAIL idle_after_reset cycle %0d: got en=%0b fwd=%0b busy=%0b, want en=0 fwd=1 busy=0", i, enable, forward, busy);
            end
        end
        $display("test_reset: 100 idle cycles observed");
    endtask

    task automatic test_latency();
        int n;
        n = 0;
        set_btn(0, 1'b1);
        while (enable !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (n < DEB + 3 || n > DEB + 5) begin
            failures++;
            $display("FAIL press_latency: got %0d cycles, want %0d..%0d", n, DEB + 3, DEB + 5);
        end
        set_btn(0, 1'b0);
        step(DEB + 6);
        model_buttons(1'b1, 1'b0);
        checks++;
        if ({enable, forward, busy} !== {exp_en(), m_fwd, exp_busy()}) begin
            failures++;
            $display("FAIL latency_state: got en=%0b fwd=%0b busy=%0b, want en=%0b fwd=%0b busy=%0b",
                     enable, forward, busy, exp_en(), m_fwd, exp_busy());
        end
        $display("test_latency: press to enable took %0d cycles", n);
    endtask

    task automatic test_glitch_start();
        int n;
        bit dropped;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            btn_start = (i % 2) == 0;
            step(1);
        end
        btn_start = 1'b1;
        n = 0;
        while (enable !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        checks++;
        if (enable !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start_enable: got en=%0b after %0d cycles, want en=1 within 10", enable, n);
        end
        dropped = 1'b0;
        for (int i = n; i < 20; i++) begin
            step(1);
            if (enable !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin
            failures++;
            $display("FAIL glitch_single_pulse: got enable drop while held, want en=1 throughout");
        end
        btn_start = 1'b0;
        step(DEB + 6);
        model_buttons(1'b1, 1'b0);
        checks++;
        if ({enable, forward, busy} !== {exp_en(), m_fwd, exp_busy()}) begin
            failures++;
            $display("FAIL glitch_release: got en=%0b fwd=%0b busy=%0b, want en=%0b fwd=%0b busy=%0b",
                     enable, forward, busy, exp_en(), m_fwd, exp_busy());
        end
        $display("test_glitch_start: enable after %0d cycles", n);
    endtask

    task automatic test_dir_control();
        for (int k = 0; k < 4; k++) begin
            // dir in RUN, start (pause), dir in PAUSE, start (resume)
            if ((k % 2) == 0) begin
                press(1, k[1]);
                model_buttons(1'b0, 1'b1);
            end else begin
                press(0, k[1]);
                model_buttons(1'b1, 1'b0);
            end
            checks++;
            if ({enable, forward, busy} !== {exp_en(), m_fwd, exp_busy()}) begin
                failures++;
                $display("FAIL dir_control step %0d: got en=%0b fwd=%0b busy=%0b, want en=%0b fwd=%0b busy=%0b",
                         k, enable, forward, busy, exp_en(), m_fwd, exp_busy());
            end
            $display("test_dir_control: step %0d en=%0b fwd=%0b busy=%0b", k, enable, forward, busy);
        end
    endtask

    task automatic test_finish();
        do_reset();
        press(0, 1'b0);
        model_buttons(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                pulse_fin();
                model_finish();
            end else begin
                press(0, 1'b0);
                model_buttons(1'b1, 1'b0);
            end
            checks++;
            if ({enable, forward, busy} !== {exp_en(), m_fwd, exp_busy()}) begin
                failures++;
                $display("FAIL finish step %0d: got en=%0b fwd=%0b busy=%0b, want en=%0b fwd=%0b busy=%0b",
                         k, enable, forward, busy, exp_en(), m_fwd, exp_busy());
            end
            $display("test_finish: step %0d en=%0b fwd=%0b busy=%0b", k, enable, forward, busy);
        end
    endtask

    task automatic test_coincident_start_dir();
        do_reset();
        press(2, 1'b0);
        model_buttons(1'b1, 1'b1);
        checks++;
        if ({enable, forward, busy} !== {exp_en(), m_fwd, exp_busy()}) begin
            failures++;
            $display("FAIL start_dir_same_edge: got en=%0b fwd=%0b busy=%0b, want en=%0b fwd=%0b busy=%0b",
                     enable, forward, busy, exp_en(), m_fwd, exp_busy());
        end
        $display("test_coincident_start_dir: en=%0b fwd=%0b busy=%0b", enable, forward, busy);
    endtask

    // finish is raised DEB cycles after btn_start, so the synchronised finish edge
    // and the debounced start edge land on the same cycle.
    task automatic test_coincident_fin_start();
        bit en_low;
        do_reset();
        press(0, 1'b0);
        model_buttons(1'b1, 1'b0);
        btn_start = 1'b1;
        step(DEB);
        finish = 1'b1;
        en_low = 1'b0;
        for (int i = 0; i < DEB + 8; i++) begin
            step(1);
            if (enable !== 1'b1) en_low = 1'b1;
        end
        btn_start = 1'b0;
        finish    = 1'b0;
        step(DEB + 6);
        model_finish();
`ifdef AUTO_REVERSE_EN
        checks++;
        if (en_low) begin
            failures++;
            $display("FAIL fin_start_enable_held: got enable drop, want en=1 throughout");
        end
`endif
        checks++;
        if ({enable, forward, busy} !== {exp_en(), m_fwd, exp_busy()}) begin
            failures++;
            $display("FAIL fin_start_priority: got en=%0b fwd=%0b busy=%0b, want en=%0b fwd=%0b busy=%0b",
                     enable, forward, busy, exp_en(), m_fwd, exp_busy());
        end
        // A follow-up start separates DONE (-> IDLE) from a wrongly entered PAUSE (-> RUN).
        press(0, 1'b0);
        model_buttons(1'b1, 1'b0);
        checks++;
        if ({enable, forward, busy} !== {exp_en(), m_fwd, exp_busy()}) begin
            failures++;
            $display("FAIL fin_start_followup: got en=%0b fwd=%0b busy=%0b, want en=%0b fwd=%0b busy=%0b",
                     enable, forward, busy, exp_en(), m_fwd, exp_busy());
        end
        $display("test_coincident_fin_start: en=%0b fwd=%0b busy=%0b", enable, forward, busy);
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        press(0, 1'b0);
        model_buttons(1'b1, 1'b0);
        checks++;
        if (enable !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_setup: got en=%0b, want en=1", enable);
        end
        btn_start = 1'b1;    // partially debounced press when reset hits
        step(2);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({enable, forward, busy} !== 3'b010) begin
            failures++;
            $display("FAIL async_reset: got en=%0b fwd=%0b busy=%0b before next edge, want en=0 fwd=1 busy=0",
                     enable, forward, busy);
        end
        btn_start = 1'b0;
        step(2);
        rst_n = 1'b1;
        model_reset();
        step(DEB + 10);
        checks++;
        if ({enable, forward, busy} !== 3'b010) begin
            failures++;
            $display("FAIL reset_release_idle: got en=%0b fwd=%0b busy=%0b, want en=0 fwd=1 busy=0",
                     enable, forward, busy);
        end
        $display("test_reset_mid_run: en=%0b fwd=%0b busy=%0b", enable, forward, busy);
    endtask

    task automatic test_random();
        int op;
        bit bounce;
        for (int t = 0; t < 40; t++) begin
            op     = $urandom_range(0, 9);
            bounce = 1'($urandom_range(0, 1));
            if (op <= 2) begin
                press(0, bounce);
                model_buttons(1'b1, 1'b0);
            end else if (op <= 4) begin
                press(1, bounce);
                model_buttons(1'b0, 1'b1);
            end else if (op == 5) begin
                press(2, 1'b0);
                model_buttons(1'b1, 1'b1);
            end else if (op <= 8) begin
                pulse_fin();
                model_finish();
            end else begin
                do_reset();
            end
            checks++;
            if ({enable, forward, busy} !== {exp_en(), m_fwd, exp_busy()}) begin
                failures++;
                $display("FAIL random txn %0d op %0d: got en=%0b fwd=%0b busy=%0b, want en=%0b fwd=%0b busy=%0b",
                         t, op, enable, forward, busy, exp_en(), m_fwd, exp_busy());
            end
            $display("random txn %0d: op=%0d bounce=%0b en=%0b fwd=%0b busy=%0b", t, op, bounce, enable, forward, busy);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch_start();
        test_dir_control();
        test_finish();
        test_coincident_start_dir();
        test_coincident_fin_start();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
